// File: rtl/writeback_unit.sv
// RV32I writeback stage: retires one instruction per cycle into the register file,
// holding loads until the data-memory response and extracting/extending the result.
module writeback_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic            ex_wen,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_result,
   input  logic            ex_is_load,
   input  logic [2:0]      ex_funct3,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_wen,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   output logic            busy,
   output logic [31:0]     instret
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      COMMIT   = 2'd2
   } state_e;

   state_e          state_q;
   logic            wen_q;
   logic [4:0]      rd_q;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;
   logic            rf_wen_q;
   logic [4:0]      rf_rd_q;
   logic [XLEN-1:0] rf_wdata_q;
   logic            busy_q;
   logic [31:0]     instret_q;
   logic            xfer;
   logic [XLEN-1:0] load_d;

   function automatic logic [XLEN-1:0] extract(
      input logic [2:0]      f3,
      input logic [1:0]      off,
      input logic [XLEN-1:0] w
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [XLEN-1:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{(XLEN-8){b[7]}}, b};
         3'b001:  r = {{(XLEN-16){h[15]}}, h};
         3'b100:  r = {{(XLEN-8){1'b0}}, b};
         3'b101:  r = {{(XLEN-16){1'b0}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign ex_ready = (state_q != WAIT_MEM);
   assign xfer     = ex_valid & ex_ready;
   assign load_d   = extract(f3_q, off_q, mem_rdata);

   assign rf_wen   = rf_wen_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;
   assign busy     = busy_q;
   assign instret  = instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wen_q      <= 1'b0;
         rd_q       <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         rf_wen_q   <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         busy_q     <= 1'b0;
         instret_q  <= '0;
      end else begin
         // Every cycle spent in COMMIT retires exactly one instruction.
         if (state_q == COMMIT)
            instret_q <= instret_q + 32'd1;
         case (state_q)
            WAIT_MEM: begin
               if (mem_rsp_valid) begin
                  state_q    <= COMMIT;
                  busy_q     <= 1'b0;
                  rf_wen_q   <= wen_q & (rd_q != 5'd0);
                  rf_rd_q    <= rd_q;
                  rf_wdata_q <= load_d;
               end
            end
            default: begin
               if (xfer && ex_is_load) begin
                  state_q  <= WAIT_MEM;
                  busy_q   <= 1'b1;
                  rf_wen_q <= 1'b0;
                  wen_q    <= ex_wen;
                  rd_q     <= ex_rd;
                  f3_q     <= ex_funct3;
                  off_q    <= ex_result[1:0];
               end else if (xfer) begin
                  state_q    <= COMMIT;
                  rf_wen_q   <= ex_wen & (ex_rd != 5'd0);
                  rf_rd_q    <= ex_rd;
                  rf_wdata_q <= ex_result;
               end else begin
                  state_q  <= IDLE;
                  rf_wen_q <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
